// File: rtl/mac_result_buffer.sv
// Result buffer behind a MAC stage: registers the raw result, converts it to a
// saturated int8 value (optional ReLU first) and queues it in a show-ahead FIFO.
module mac_result_buffer #(
  parameter int DEPTH   = 4,
  parameter int RELU_EN = 1
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [10:0]              i_in_data,
  input  logic                     i_in_valid,
  output logic [7:0]               o_out_data,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_overflow,
  output logic                     o_sat_flag
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic signed [10:0] r_s_data;
  logic               r_s_valid;
  logic [7:0]         r_mem [DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic               r_overflow;
  logic               r_sat_flag;

  logic [7:0]         w_conv;
  logic               w_clip;
  logic               w_push;
  logic               w_pop;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_s_valid <= 1'b0;
      r_s_data  <= '0;
    end else begin
      r_s_valid <= i_in_valid;
      r_s_data  <= i_in_data;
    end
  end

  // ReLU clamp has priority and is not counted as saturation.
  always_comb begin
    w_conv = r_s_data[7:0];
    w_clip = 1'b0;
    if ((RELU_EN != 0) && (r_s_data < 0)) begin
      w_conv = 8'h00;
    end else if (r_s_data > 11'sd127) begin
      w_conv = 8'h7f;
      w_clip = 1'b1;
    end else if (r_s_data < -11'sd128) begin
      w_conv = 8'h80;
      w_clip = 1'b1;
    end
  end

  assign o_out_valid = (r_count != '0);
  assign o_full      = (r_count == CW'(DEPTH));
  assign w_pop       = o_out_valid && i_out_ready;
  assign w_push      = r_s_valid && (!o_full || w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_conv;
    end
  end

  // DEPTH is a power of two, so pointer wrap is the natural binary rollover.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_sat_flag <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (r_s_valid && !w_push) begin
        r_overflow <= 1'b1;
      end
      if (w_push && w_clip) begin
        r_sat_flag <= 1'b1;
      end
    end
  end

  assign o_out_data = r_mem[r_rd_ptr];
  assign o_count    = r_count;
  assign o_overflow = r_overflow;
  assign o_sat_flag = r_sat_flag;

endmodule
